pin_turnaround_sched: RTL and testbench

Time-division scheduler for a bank of bidirectional iCE40 pins, each wired through an `SB_IO` in tristate mode (PIN_TYPE 1010_01). It owns every pin's output-enable and output data: it drives each pin in turn with a bit of a latched pattern, releases it for a turnaround window, then samples the pin's input. The core supplies patterns through a valid/ready handshake and receives one sampled vector per frame. Its outputs connect directly to the `SB_IO` OUTPUT_ENABLE, D_OUT_0 and D_IN_0 vectors. LED/button-sharing designs use it in place of free-running counter bits on OUTPUT_ENABLE.

---
 rtl/pin_turnaround_sched.sv | 159 +++++++++++++++
 tb/tb_pin_turnaround_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pin_turnaround_sched.sv
// pin_turnaround_sched: time-division drive/release/sample scheduler for a
// bank of bidirectional tristate pins. Each pin in turn is driven with one
// bit of a latched pattern, released for a turnaround window, then sampled
// through a 2-flop synchronizer. A full sampled vector is published once per
// frame with a one-cycle valid pulse.
module pin_turnaround_sched #(
  parameter int NPINS        = 4,
  parameter int DRIVE_CYCLES = 16,
  parameter int TURN_CYCLES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPINS-1:0] pattern,
  input  logic             pattern_valid,
  output logic             pattern_ready,
  output logic [NPINS-1:0] pin_oe,
  output logic [NPINS-1:0] pin_dout,
  input  logic [NPINS-1:0] pin_din,
  output logic [NPINS-1:0] samples,
  output logic             samples_valid,
  output logic             busy
);

  localparam int IW   = (NPINS > 1) ? $clog2(NPINS) : 1;
  localparam int CMAX = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    TURN   = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic [CW-1:0]    cnt_reg;
  logic [NPINS-1:0] pat_q_reg;
  logic [NPINS-1:0] shadow_reg;
  logic [NPINS-1:0] samples_reg;
  logic             samples_valid_reg;
  logic [NPINS-1:0] pin_oe_reg;
  logic [NPINS-1:0] pin_dout_reg;
  logic             ready_reg;
  logic             busy_reg;

  logic [NPINS-1:0] din_meta_reg;
  logic [NPINS-1:0] din_s_reg;

  // Next pin index and the per-bit views derived from it.
  logic [IW-1:0]    idx_inc;
  logic [NPINS-1:0] onehot_inc;
  logic [NPINS-1:0] shadow_cap;

  assign idx_inc = idx_reg + IW'(1);

  // Per-pin decode: one-hot select of the next pin, and the shadow vector
  // with the current pin's synchronized level merged in.
  genvar gi;
  generate
    for (gi = 0; gi < NPINS; gi = gi + 1) begin : g_pin
      assign onehot_inc[gi] = (idx_inc == IW'(gi));
      assign shadow_cap[gi] = (idx_reg == IW'(gi)) ? din_s_reg[gi] : shadow_reg[gi];
    end
  endgenerate

  // Two-flop synchronizer for the asynchronous pad inputs, always running.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_meta_reg <= '0;
      din_s_reg    <= '0;
    end else begin
      din_meta_reg <= pin_din;
      din_s_reg    <= din_meta_reg;
    end
  end

  // Scheduler FSM; all pad-facing and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      idx_reg           <= '0;
      cnt_reg           <= '0;
      pat_q_reg         <= '0;
      shadow_reg        <= '0;
      samples_reg       <= '0;
      samples_valid_reg <= 1'b0;
      pin_oe_reg        <= '0;
      pin_dout_reg      <= '0;
      ready_reg         <= 1'b1;
      busy_reg          <= 1'b0;
    end else begin
      samples_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pattern_valid) begin
            pat_q_reg    <= pattern;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            state_reg    <= DRIVE;
            pin_oe_reg   <= NPINS'(1);
            pin_dout_reg <= NPINS'(pattern[0]);
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_reg == CW'(DRIVE_CYCLES - 1)) begin
            cnt_reg      <= '0;
            state_reg    <= TURN;
            pin_oe_reg   <= '0;
            pin_dout_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        TURN: begin
          if (cnt_reg == CW'(TURN_CYCLES - 1)) begin
            cnt_reg   <= '0;
            state_reg <= SAMPLE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SAMPLE: begin
          shadow_reg <= shadow_cap;
          if (idx_reg == IW'(NPINS - 1)) begin
            samples_reg       <= shadow_cap;
            samples_valid_reg <= 1'b1;
            state_reg         <= IDLE;
            ready_reg         <= 1'b1;
            busy_reg          <= 1'b0;
          end else begin
            idx_reg      <= idx_inc;
            cnt_reg      <= '0;
            state_reg    <= DRIVE;
            pin_oe_reg   <= onehot_inc;
            pin_dout_reg <= onehot_inc & pat_q_reg;
          end
        end
        default: begin
          state_reg    <= IDLE;
          pin_oe_reg   <= '0;
          pin_dout_reg <= '0;
          ready_reg    <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign pattern_ready = ready_reg;
  assign busy          = busy_reg;
  assign pin_oe        = pin_oe_reg;
  assign pin_dout      = pin_dout_reg;
  assign samples       = samples_reg;
  assign samples_valid = samples_valid_reg;

endmodule

// File: tb/tb_pin_turnaround_sched.sv
// Directed bench for pin_turnaround_sched with NPINS=4, DRIVE=4, TURN=3:
// one slot is 8 cycles, one frame 32 cycles, samples_valid 32 cycles after
// the accepting edge.
module tb_pin_turnaround_sched;

  logic       clk;
  logic       rst;
  logic [3:0] pattern;
  logic       pattern_valid;
  logic       pattern_ready;
  logic [3:0] pin_oe;
  logic [3:0] pin_dout;
  logic [3:0] pin_din;
  logic [3:0] samples;
  logic       samples_valid;
  logic       busy;

  int total;
  int bad;

  pin_turnaround_sched #(
    .NPINS(4),
    .DRIVE_CYCLES(4),
    .TURN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pattern(pattern),
    .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready),
    .pin_oe(pin_oe),
    .pin_dout(pin_dout),
    .pin_din(pin_din),
    .samples(samples),
    .samples_valid(samples_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame starting from IDLE. n counts edges since the accepting
  // edge: pin p = n/8 is driven for n%8 in 0..3, released otherwise; n=32
  // is the first IDLE cycle carrying the samples_valid pulse.
  task automatic run_frame(input logic [3:0] pat, input logic [3:0] din,
                           input logic [3:0] exp_s, input bit hold,
                           input logic [3:0] mid_pat, input bit mid,
                           input bit toggle);
    logic [3:0] e_oe;
    logic [3:0] e_dout;
    int p;
    check("ready_pre", {31'd0, pattern_ready}, 32'd1);
    pattern       = pat;
    pattern_valid = 1'b1;
    pin_din       = din;
    for (int n = 0; n <= 32; n++) begin
      tick();
      p = n / 8;
      if (n < 32 && (n % 8) < 4) e_oe = 4'b0001 << p;
      else e_oe = 4'b0000;
      e_dout = e_oe & pat;
      check("oe", {28'd0, pin_oe}, {28'd0, e_oe});
      check("dout", {28'd0, pin_dout}, {28'd0, e_dout});
      check("svalid", {31'd0, samples_valid}, (n == 32) ? 32'd1 : 32'd0);
      check("ready", {31'd0, pattern_ready}, (n == 32) ? 32'd1 : 32'd0);
      check("busy", {31'd0, busy}, (n == 32) ? 32'd0 : 32'd1);
      if (n == 32) check("samples", {28'd0, samples}, {28'd0, exp_s});
      if (n == 0 && !hold) pattern_valid = 1'b0;
      if (mid && n == 10) begin
        pattern       = mid_pat;
        pattern_valid = 1'b1;
      end
      if (toggle && n >= 8 && n < 12) pin_din[1] = (n != 9);
      if (toggle && n == 12) pin_din = din;
    end
    $display("frame pat=%b din=%b samples=%b", pat, din, samples);
  endtask

  initial begin
    int pulses;
    logic [3:0] e_oe;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    pattern       = 4'b0000;
    pattern_valid = 1'b0;
    pin_din       = 4'b0000;

    // Reset and idle
    tick();
    check("rst_ready", {31'd0, pattern_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (samples_valid) pulses++;
      check("idle_oe", {28'd0, pin_oe}, 32'd0);
      check("idle_dout", {28'd0, pin_dout}, 32'd0);
      check("idle_ready", {31'd0, pattern_ready}, 32'd1);
      check("idle_samples", {28'd0, samples}, 32'd0);
    end
    check("idle_pulses", pulses, 32'd0);
    $display("reset/idle done");

    // Basic frame
    run_frame(4'b1010, 4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Continuous valid: back-to-back frames with one gap cycle
    run_frame(4'b0011, 4'b1100, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_frame(4'b0011, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_frame(4'b0011, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Mid-frame pattern change is ignored; producer holds it into next IDLE
    run_frame(4'b1100, 4'b0101, 4'b0101, 1'b0, 4'b0011, 1'b1, 1'b0);
    run_frame(4'b0011, 4'b1010, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Pad toggles during its own drive window, held through turnaround
    run_frame(4'b0110, 4'b1001, 4'b1001, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Reset during pin 2 drive
    pattern       = 4'b1111;
    pattern_valid = 1'b1;
    pin_din       = 4'b0000;
    for (int n = 0; n <= 17; n++) begin
      tick();
      if ((n % 8) < 4) e_oe = 4'b0001 << (n / 8);
      else e_oe = 4'b0000;
      check("pre_rst_oe", {28'd0, pin_oe}, {28'd0, e_oe});
      if (n == 0) pattern_valid = 1'b0;
      if (n == 17) rst = 1'b1;
    end
    tick();
    check("rst_oe", {28'd0, pin_oe}, 32'd0);
    check("rst_dout", {28'd0, pin_dout}, 32'd0);
    check("rst_samples", {28'd0, samples}, 32'd0);
    check("rst_svalid", {31'd0, samples_valid}, 32'd0);
    check("rst_ready", {31'd0, pattern_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (samples_valid) pulses++;
      if (pin_oe != 4'b0000) pulses++;
    end
    check("post_rst_quiet", pulses, 32'd0);
    $display("mid-frame reset done");

    // Restart from pin 0
    run_frame(4'b0101, 4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
